// File: rtl/ntt_row_sched.sv
// Row scheduler for an NTT pass: walks the coefficient memory row by row and
// streams each row to a consumer over a valid/ready handshake, counting
// back-pressure cycles. One register stage sits between memory and consumer.
module ntt_row_sched #(
    parameter int unsigned NUM_ROWS = 128,
    parameter int unsigned LANES    = 128,
    parameter int unsigned DATA_W   = 12,
    localparam int unsigned ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int unsigned ROW_BITS = LANES * DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    output logic [ROW_W-1:0]    row_o,
    input  logic [ROW_BITS-1:0] mem_data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [ROW_BITS-1:0] data_o,
    output logic [ROW_W-1:0]    row_idx_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [15:0]         stall_cnt_o
);

    localparam int unsigned PTR_W = ROW_W + 1;
    localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(NUM_ROWS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ROWS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic                valid_q;
    logic                last_q;
    logic                busy_q;
    logic                done_q;
    logic [ROW_W-1:0]    row_idx_q;
    logic [ROW_BITS-1:0] data_q;
    logic [15:0]         stall_cnt_q;

    logic hs_c;
    logic stall_c;
    logic load_c;
    logic last_fetch_c;

    // Handshake, stall and load qualifiers plus the memory read address.
    always_comb begin
        hs_c         = valid_q && ready_i;
        stall_c      = valid_q && !ready_i;
        load_c       = (state_q == S_RUN) && (rd_ptr_q < PTR_END) && (!valid_q || ready_i);
        last_fetch_c = (rd_ptr_q == PTR_LAST);
        row_o        = (state_q == S_RUN) ? rd_ptr_q[ROW_W-1:0] : '0;
    end

    // Pass sequencing FSM with the output register stage; abort beats a same-cycle load.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            row_idx_q   <= '0;
            data_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (stall_c && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rd_ptr_q    <= '0;
                        stall_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (load_c) begin
                        data_q    <= mem_data_i;
                        row_idx_q <= rd_ptr_q[ROW_W-1:0];
                        valid_q   <= 1'b1;
                        last_q    <= last_fetch_c;
                        rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                        if (last_fetch_c) begin
                            state_q <= S_DRAIN;
                        end
                    end else if (hs_c) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (abort_i) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (hs_c) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign row_idx_o   = row_idx_q;
    assign last_o      = last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ntt_row_sched.sv
// Bench for ntt_row_sched: expected stream is rows 0..N-1 in order with data
// from the memory pattern; each pass is checked against that stream.
module tb_ntt_row_sched;

    localparam int unsigned N   = 128;
    localparam int unsigned L   = 128;
    localparam int unsigned DW  = 12;
    localparam int unsigned RW  = 7;
    localparam int unsigned BW  = L * DW;
    localparam int unsigned N4  = 4;
    localparam int unsigned L4  = 4;
    localparam int unsigned RW4 = 2;
    localparam int unsigned BW4 = L4 * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort, ready;
    logic [RW-1:0] row, row_idx;
    logic [BW-1:0] mem_data, data;
    logic          valid, last, busy, done;
    logic [15:0]   stall_cnt;

    logic           start4, abort4, ready4;
    logic [RW4-1:0] row4, row_idx4;
    logic [BW4-1:0] mem_data4, data4;
    logic           valid4, last4, busy4, done4;
    logic [15:0]    stall_cnt4;

    int seed;
    int n_chk = 0;
    int n_fail = 0;

    ntt_row_sched u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .row_o(row), .mem_data_i(mem_data), .valid_o(valid), .ready_i(ready),
        .data_o(data), .row_idx_o(row_idx), .last_o(last), .busy_o(busy),
        .done_o(done), .stall_cnt_o(stall_cnt)
    );

    ntt_row_sched #(.NUM_ROWS(N4), .LANES(L4), .DATA_W(DW)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .abort_i(abort4),
        .row_o(row4), .mem_data_i(mem_data4), .valid_o(valid4), .ready_i(ready4),
        .data_o(data4), .row_idx_o(row_idx4), .last_o(last4), .busy_o(busy4),
        .done_o(done4), .stall_cnt_o(stall_cnt4)
    );

    function automatic logic [DW-1:0] pat(input int r, input int k, input int s);
        return DW'((r * 128 + k + s) % 4096);
    endfunction

    function automatic logic [BW-1:0] exp_vec(input int r);
        logic [BW-1:0] v;
        for (int k = 0; k < L; k++) v[k*DW +: DW] = pat(r, k, seed);
        return v;
    endfunction

    function automatic logic [BW4-1:0] exp_vec4(input int r);
        logic [BW4-1:0] v;
        for (int k = 0; k < L4; k++) v[k*DW +: DW] = pat(r, k, seed);
        return v;
    endfunction

    // Asynchronous-read coefficient memories
    always_comb begin
        for (int k = 0; k < L; k++) mem_data[k*DW +: DW] = pat(int'(row), k, seed);
    end
    always_comb begin
        for (int k = 0; k < L4; k++) mem_data4[k*DW +: DW] = pat(int'(row4), k, seed);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full pass. mode 0: stall sl cycles at row sr; 1: toggle ready; 2: random ready.
    task automatic run_pass(input int mode, input int sr, input int sl, input bit inj,
                            output int lat, output int stalls);
        int  cyc, exp_row, stall_left, last_hs, viol, first_bad;
        bit  got_done;
        lat = -1; stalls = 0; exp_row = 0; stall_left = sl; last_hs = -1;
        viol = 0; first_bad = -1; got_done = 0;
        @(negedge clk);
        start = 1'b1;
        ready = (mode == 1) ? 1'b0 : 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!got_done && cyc < 3000) begin
            if (done) begin
                got_done = 1'b1;
                lat = cyc;
            end else begin
                if (busy !== 1'b1) viol++;
                if (cyc == 1 && valid !== 1'b0) viol++;
                if (cyc == 2 && valid !== 1'b1) viol++;
                if (valid) begin
                    if (exp_row >= int'(N) || row_idx !== RW'(exp_row) ||
                        last !== (exp_row == int'(N) - 1) || data !== exp_vec(exp_row)) begin
                        viol++;
                        if (first_bad < 0) first_bad = exp_row;
                    end
                end else if (last !== 1'b0) begin
                    viol++;
                end
            end
            if (!got_done) begin
                case (mode)
                    0: begin
                        ready = !(valid && row_idx == RW'(sr) && stall_left > 0);
                        if (!ready) stall_left--;
                    end
                    1: ready = ~ready;
                    default: ready = ($urandom_range(0, 3) != 0);
                endcase
                if (inj) start = ($urandom_range(0, 7) == 0);
                if (valid && ready) begin
                    exp_row++;
                    last_hs = cyc;
                end
                if (valid && !ready) stalls++;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        ready = 1'b1;
        chk("done_seen", longint'(got_done), 1);
        chk($sformatf("stream_viol(first row %0d)", first_bad), viol, 0);
        chk("rows_delivered", exp_row, N);
        chk("done_after_last_hs", lat, last_hs + 1);
        chk("valid_at_done", longint'(valid), 0);
        chk("busy_at_done", longint'(busy), 0);
        chk("stall_cnt_pass", longint'(stall_cnt), stalls);
        @(negedge clk);
        chk("done_one_cycle", longint'(done), 0);
    endtask

    typedef struct {
        int sr;
        int sl;
        int exp_lat;
        int exp_stall;
    } vec_t;

    // Safety net against a hang
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [5];
        int   lat, st, n, nd;

        tbl[0] = '{0,   0,  130, 0};
        tbl[1] = '{0,   3,  133, 3};
        tbl[2] = '{50,  1,  131, 1};
        tbl[3] = '{127, 10, 140, 10};
        tbl[4] = '{100, 7,  137, 7};

        rst_n = 1'b0; start = 1'b1; abort = 1'b0; ready = 1'b1;
        start4 = 1'b0; abort4 = 1'b0; ready4 = 1'b1; seed = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", longint'(valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_last", longint'(last), 0);
        chk("rst_stall_cnt", longint'(stall_cnt), 0);
        chk("rst_row_o", longint'(row), 0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);

        // Table of single-stall passes with hand-derived completion latency
        for (int i = 0; i < 5; i++) begin
            run_pass(0, tbl[i].sr, tbl[i].sl, 1'b0, lat, st);
            chk($sformatf("tbl%0d_done_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_stall_cnt", i), longint'(stall_cnt), tbl[i].exp_stall);
        end

        // Ready toggling every cycle
        run_pass(1, 0, 0, 1'b0, lat, st);
        chk("toggle_stalls_nonzero", longint'(stall_cnt > 0), 1);

        // Abort at row 50 coinciding with a handshake
        @(negedge clk);
        start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(valid && row_idx == RW'(50)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_row50", longint'(n < 400), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", longint'(valid), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_last", longint'(last), 0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            nd += int'(done);
            @(negedge clk);
        end
        chk("abort_no_done", nd, 0);
        seed = 17;
        run_pass(0, 0, 0, 1'b0, lat, st);
        chk("restart_done_lat", lat, 130);

        // Reset for one cycle at row 64
        @(negedge clk);
        start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(valid && row_idx == RW'(64)) && n < 400) begin
            ready = ~ready;
            @(negedge clk);
            n++;
        end
        chk("rst_reach_row64", longint'(n < 400), 1);
        rst_n = 1'b0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        chk("midrst_valid", longint'(valid), 0);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_last", longint'(last), 0);
        chk("midrst_row_idx", longint'(row_idx), 0);
        chk("midrst_data_zero", longint'(data == '0), 1);
        chk("midrst_stall_cnt", longint'(stall_cnt), 0);
        nd = 0;
        for (int i = 0; i < 150; i++) begin
            nd += int'(done) + int'(busy);
            @(negedge clk);
        end
        chk("midrst_no_done_busy", nd, 0);

        // Random back-pressure with start_i pulses sprinkled through the pass
        for (int p = 0; p < 4; p++) begin
            seed = int'($urandom_range(0, 4000));
            run_pass(2, 0, 0, 1'b1, lat, st);
        end

        // Four-row build, ready held high
        seed = 5;
        @(negedge clk);
        start4 = 1'b1; ready4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("n4_valid_c%0d", c), longint'(valid4), longint'(c >= 2 && c <= 5));
            chk($sformatf("n4_done_c%0d", c), longint'(done4), longint'(c == 6));
            chk($sformatf("n4_last_c%0d", c), longint'(last4), longint'(c == 5));
            if (c >= 2 && c <= 5) begin
                chk($sformatf("n4_row_c%0d", c), longint'(row_idx4), c - 2);
                chk($sformatf("n4_data_c%0d", c), longint'(data4 == exp_vec4(c - 2)), 1);
            end
            @(negedge clk);
        end
        chk("n4_stall_cnt", longint'(stall_cnt4), 0);
        chk("n4_busy_after", longint'(busy4), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
